// File: rtl/lane_ram.sv
// lane_ram: single-port word RAM behind a req/ack handshake with byte-lane
// write enables and a configurable number of wait states per access.
// Optional write protection of the low address region is compiled in when
// the macro LANE_RAM_WRPROT_EN is defined (adds port wp, parameter WP_LIMIT).
module lane_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int WAIT   = 0
`ifdef LANE_RAM_WRPROT_EN
  ,
  parameter int WP_LIMIT = 256
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                rw,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   data_write,
`ifdef LANE_RAM_WRPROT_EN
  input  logic                wp,
`endif
  output logic [DATA_W-1:0]   data_read,
  output logic                ack,
  output logic                busy,
  output logic                err
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [LANES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                prot_q, prot_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Transaction that commits on the edge entering ACK: taken straight from
  // the inputs when ACK follows IDLE directly, otherwise from the latches.
  logic                commit;
  logic                prot_in;
  logic                use_in;
  logic [ADDR_W-1:0]   c_addr;
  logic                c_rw;
  logic [LANES-1:0]    c_be;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_prot;

`ifdef LANE_RAM_WRPROT_EN
  // Protected region: writes below WP_LIMIT while wp is high are refused.
  assign prot_in = wp && !rw && (32'(addr) < 32'(WP_LIMIT));
`else
  assign prot_in = 1'b0;
`endif

  assign use_in  = (state_q == S_IDLE);
  assign c_addr  = use_in ? addr       : addr_q;
  assign c_rw    = use_in ? rw         : rw_q;
  assign c_be    = use_in ? be         : be_q;
  assign c_wdata = use_in ? data_write : wdata_q;
  assign c_prot  = use_in ? prot_in    : prot_q;

  // Next-state logic: accept in IDLE, count wait states, pulse ack in ACK.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    prot_d  = prot_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          rw_d    = rw;
          be_d    = be;
          wdata_d = data_write;
          prot_d  = prot_in;
          cnt_d   = 4'd0;
          if (WAIT == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d  = commit;
    err_d  = commit && c_prot;
    busy_d = (state_d != S_IDLE);
  end

  // Control and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      prot_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      prot_q  <= prot_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane write port; lanes with a clear enable keep their contents.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto RAM macros; reset only
    // blocks a write from landing while it is asserted.
    if (reset_n && commit && !c_rw && !c_prot) begin
      for (int i = 0; i < LANES; i++) begin
        if (c_be[i]) mem[c_addr][i*8 +: 8] <= c_wdata[i*8 +: 8];
      end
    end
  end

  // Read data register: loads the full word on read commit, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (commit && c_rw) begin
      rdata_q <= mem[c_addr];
    end
  end

  assign data_read = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
`ifdef LANE_RAM_WRPROT_EN
  assign err       = err_q;
`else
  assign err       = err_q & prot_q;
`endif

endmodule

// File: tb/tb_lane_ram.sv
// tb_lane_ram: self-checking bench for lane_ram. Two instances: A with
// DATA_W=16/ADDR_W=18/WAIT=0 and B with DATA_W=32/ADDR_W=4/WAIT=3.
// Write-protection checks are included when LANE_RAM_WRPROT_EN is defined.
module tb_lane_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LANE_RAM_WRPROT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  // Instance A signals
  logic        a_rst_n, a_req, a_rw, a_wp;
  logic [17:0] a_addr;
  logic [1:0]  a_be;
  logic [15:0] a_wd, a_rd;
  logic        a_ack, a_busy, a_err;
  // Instance B signals
  logic        b_rst_n, b_req, b_rw, b_wp;
  logic [3:0]  b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wd, b_rd;
  logic        b_ack, b_busy, b_err;

  lane_ram #(.DATA_W(16), .ADDR_W(18), .WAIT(0)) u_a (
    .clk(clk), .reset_n(a_rst_n), .req(a_req), .addr(a_addr), .rw(a_rw),
    .be(a_be), .data_write(a_wd),
`ifdef LANE_RAM_WRPROT_EN
    .wp(a_wp),
`endif
    .data_read(a_rd), .ack(a_ack), .busy(a_busy), .err(a_err)
  );

  lane_ram #(.DATA_W(32), .ADDR_W(4), .WAIT(3)) u_b (
    .clk(clk), .reset_n(b_rst_n), .req(b_req), .addr(b_addr), .rw(b_rw),
    .be(b_be), .data_write(b_wd),
`ifdef LANE_RAM_WRPROT_EN
    .wp(b_wp),
`endif
    .data_read(b_rd), .ack(b_ack), .busy(b_busy), .err(b_err)
  );

  // Reference model state
  logic [15:0] model_a [int];
  logic [15:0] a_exp_rd;
  logic [31:0] b_exp_rd;

  function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] lanes);
    logic [15:0] r;
    r = old_v;
    if (lanes[0]) r[7:0]  = new_v[7:0];
    if (lanes[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  // One access on A; inputs are scrambled and req dropped right after accept.
  task automatic acc_a(input logic r, input logic [17:0] ad, input logic [1:0] b,
                       input logic [15:0] wd, input logic p,
                       output logic [15:0] rd, output logic er, output int n);
    @(negedge clk);
    a_req = 1'b1; a_rw = r; a_addr = ad; a_be = b; a_wd = wd; a_wp = p;
    @(posedge clk);
    #1;
    a_req = 1'b0; a_rw = 1'($urandom); a_addr = 18'($urandom);
    a_be = 2'($urandom); a_wd = 16'($urandom); a_wp = 1'($urandom);
    n = 0; rd = '0; er = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      if (a_ack === 1'b1) break;
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL a_ack_timeout: no ack within %0d cycles", n);
    end else begin
      rd = a_rd; er = a_err;
      @(negedge clk);
      n_cmp++;
      if (a_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL a_ack_pulse: ack=%b in cycle after ack, required 0", a_ack);
      end
    end
  endtask

  // One access on B, also observing busy and data_read during wait states.
  task automatic acc_b(input logic r, input int ad, input logic [3:0] b, input logic [31:0] wd,
                       output logic [31:0] rd, output int n, output logic pre_ok,
                       output logic busy_at_ack, output logic busy_after);
    logic [31:0] prev;
    @(negedge clk);
    prev = b_rd;
    b_req = 1'b1; b_rw = r; b_addr = 4'(ad); b_be = b; b_wd = wd; b_wp = 1'b0;
    @(posedge clk);
    #1;
    b_req = 1'b0; b_rw = 1'($urandom); b_addr = 4'($urandom);
    b_be = 4'($urandom); b_wd = $urandom;
    n = 0; rd = '0; pre_ok = 1'b1; busy_at_ack = 1'b0; busy_after = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      if (b_ack === 1'b1) break;
      if (b_busy !== 1'b1 || b_rd !== prev) pre_ok = 1'b0;
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL b_ack_timeout: no ack within %0d cycles", n);
    end else begin
      rd = b_rd; busy_at_ack = b_busy;
      @(negedge clk);
      busy_after = b_busy;
      n_cmp++;
      if (b_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL b_ack_pulse: ack=%b in cycle after ack, required 0", b_ack);
      end
    end
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req = 0; a_rw = 0; a_addr = '0; a_be = '0; a_wd = '0; a_wp = 0;
    b_req = 0; b_rw = 0; b_addr = '0; b_be = '0; b_wd = '0; b_wp = 0;
    #3;
    n_cmp++; if ({a_ack, a_busy, a_err} !== 3'b000) begin n_bad++;
      $display("FAIL reset_a_ctrl: ack/busy/err=%b required 000", {a_ack, a_busy, a_err}); end
    n_cmp++; if (a_rd !== 16'h0) begin n_bad++;
      $display("FAIL reset_a_rd: got %h required 0000", a_rd); end
    n_cmp++; if ({b_ack, b_busy, b_err} !== 3'b000) begin n_bad++;
      $display("FAIL reset_b_ctrl: ack/busy/err=%b required 000", {b_ack, b_busy, b_err}); end
    n_cmp++; if (b_rd !== 32'h0) begin n_bad++;
      $display("FAIL reset_b_rd: got %h required 00000000", b_rd); end
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_exp_rd = 16'h0; b_exp_rd = 32'h0;
  endtask

  task automatic test_basic();
    logic [15:0] rd; logic er; int n;
    acc_a(1'b0, 18'h10, 2'b11, 16'hBEEF, 1'b0, rd, er, n);
    model_a[32'h10] = 16'hBEEF;
    n_cmp++; if (n != 0) begin n_bad++;
      $display("FAIL basic_wr_latency: %0d extra edges, required 0", n); end
    n_cmp++; if (er !== 1'b0) begin n_bad++;
      $display("FAIL basic_wr_err: got %b required 0", er); end
    acc_a(1'b1, 18'h10, 2'b00, 16'h0, 1'b0, rd, er, n);
    a_exp_rd = 16'hBEEF;
    n_cmp++; if (n != 0) begin n_bad++;
      $display("FAIL basic_rd_latency: %0d extra edges, required 0", n); end
    n_cmp++; if (rd !== a_exp_rd) begin n_bad++;
      $display("FAIL basic_rd_data: got %h required %h", rd, a_exp_rd); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd; logic er; int n;
    acc_a(1'b0, 18'h5, 2'b11, 16'h1234, 1'b0, rd, er, n);
    acc_a(1'b0, 18'h5, 2'b10, 16'hAB00, 1'b0, rd, er, n);
    acc_a(1'b1, 18'h5, 2'b00, 16'h0, 1'b0, rd, er, n);
    n_cmp++; if (rd !== 16'hAB34) begin n_bad++;
      $display("FAIL lanes_upper: got %h required AB34", rd); end
    acc_a(1'b0, 18'h5, 2'b01, 16'h00CD, 1'b0, rd, er, n);
    n_cmp++; if (rd !== 16'hAB34) begin n_bad++;
      $display("FAIL lanes_rd_hold: data_read %h changed by write, required AB34", rd); end
    acc_a(1'b1, 18'h5, 2'b00, 16'h0, 1'b0, rd, er, n);
    n_cmp++; if (rd !== 16'hABCD) begin n_bad++;
      $display("FAIL lanes_lower: got %h required ABCD", rd); end
    acc_a(1'b0, 18'h5, 2'b00, 16'h9999, 1'b0, rd, er, n);
    n_cmp++; if (n >= 20) begin n_bad++;
      $display("FAIL lanes_be0_ack: no ack for be=00 write"); end
    acc_a(1'b1, 18'h5, 2'b11, 16'h0, 1'b0, rd, er, n);
    n_cmp++; if (rd !== 16'hABCD) begin n_bad++;
      $display("FAIL lanes_be0_nochange: got %h required ABCD", rd); end
    model_a[32'h5] = 16'hABCD;
    a_exp_rd = 16'hABCD;
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat; logic [15:0] rd2;
    @(negedge clk);
    a_req = 1'b1; a_rw = 1'b0; a_addr = 18'h2A5; a_be = 2'b11; a_wd = 16'h7E57; a_wp = 1'b0;
    @(posedge clk);
    #1;
    a_rw = 1'b1; a_wd = 16'h0000;
    rd2 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat[i] = a_ack;
      if (i == 2) begin rd2 = a_rd; a_req = 1'b0; end
    end
    model_a[32'h2A5] = 16'h7E57;
    a_exp_rd = 16'h7E57;
    n_cmp++; if (pat !== 5'b00101) begin n_bad++;
      $display("FAIL b2b_ack_pattern: got %b required 00101 (bit0 = first cycle)", pat); end
    n_cmp++; if (rd2 !== a_exp_rd) begin n_bad++;
      $display("FAIL b2b_rd_data: got %h required %h", rd2, a_exp_rd); end
  endtask

  task automatic test_random();
    logic [17:0] pool [8];
    logic [15:0] rd, wd, exp_d; logic er, r, p, prot; logic [1:0] be; int n, k;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 18'($urandom) | 18'h400;
      if (i < 2) pool[i] = 18'($urandom_range(0, 255));
      wd = 16'($urandom);
      acc_a(1'b0, pool[i], 2'b11, wd, 1'b0, rd, er, n);
      model_a[int'(pool[i])] = wd;
    end
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 7);
      r = 1'($urandom); be = 2'($urandom); wd = 16'($urandom); p = 1'($urandom);
      acc_a(r, pool[k], be, wd, p, rd, er, n);
      prot = WP_ON && p && !r && (pool[k] < 18'd256);
      if (r) a_exp_rd = model_a[int'(pool[k])];
      else if (!prot) model_a[int'(pool[k])] = merge16(model_a[int'(pool[k])], wd, be);
      exp_d = a_exp_rd;
      n_cmp++; if (rd !== exp_d || er !== prot || n != 0) begin n_bad++;
        $display("FAIL rand_%0d: rw=%b addr=%h data=%h err=%b lat=%0d required data=%h err=%b lat=0",
                 t, r, pool[k], rd, er, n, exp_d, prot);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int n; logic pre_ok, bat, baf;
    acc_b(1'b0, 2, 4'hF, 32'h11223344, rd, n, pre_ok, bat, baf);
    n_cmp++; if (n != 3 || !pre_ok || bat !== 1'b1 || baf !== 1'b0) begin n_bad++;
      $display("FAIL wait_wr: lat=%0d pre_ok=%b busy@ack=%b busy_after=%b required 3 1 1 0",
               n, pre_ok, bat, baf); end
    acc_b(1'b1, 2, 4'h0, 32'h0, rd, n, pre_ok, bat, baf);
    b_exp_rd = 32'h11223344;
    n_cmp++; if (n != 3 || !pre_ok || bat !== 1'b1 || baf !== 1'b0) begin n_bad++;
      $display("FAIL wait_rd_timing: lat=%0d pre_ok=%b busy@ack=%b busy_after=%b required 3 1 1 0",
               n, pre_ok, bat, baf); end
    n_cmp++; if (rd !== b_exp_rd) begin n_bad++;
      $display("FAIL wait_rd_data: got %h required %h", rd, b_exp_rd); end
    acc_b(1'b0, 2, 4'b0101, 32'h55667788, rd, n, pre_ok, bat, baf);
    n_cmp++; if (rd !== b_exp_rd || !pre_ok) begin n_bad++;
      $display("FAIL wait_wr_hold: data_read %h pre_ok=%b required %h 1", rd, pre_ok, b_exp_rd); end
    acc_b(1'b1, 2, 4'h0, 32'h0, rd, n, pre_ok, bat, baf);
    b_exp_rd = 32'h11663388;
    n_cmp++; if (rd !== b_exp_rd) begin n_bad++;
      $display("FAIL wait_lanes32: got %h required %h", rd, b_exp_rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int n; logic pre_ok, bat, baf;
    acc_b(1'b0, 'h13, 4'hF, 32'hCAFEF00D, rd, n, pre_ok, bat, baf);
    acc_b(1'b1, 'h3, 4'h0, 32'h0, rd, n, pre_ok, bat, baf);
    b_exp_rd = 32'hCAFEF00D;
    n_cmp++; if (rd !== b_exp_rd) begin n_bad++;
      $display("FAIL wrap_rd: got %h required %h", rd, b_exp_rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; int n, acks; logic pre_ok, bat, baf;
    acc_b(1'b0, 7, 4'hF, 32'h0000_0000, rd, n, pre_ok, bat, baf);
    @(negedge clk);
    b_req = 1'b1; b_rw = 1'b0; b_addr = 4'd7; b_be = 4'hF; b_wd = 32'h5555;
    @(posedge clk);
    #1;
    b_req = 1'b0;
    @(negedge clk);
    #2;
    b_rst_n = 1'b0;
    #1;
    n_cmp++; if ({b_ack, b_busy, b_err} !== 3'b000 || b_rd !== 32'h0) begin n_bad++;
      $display("FAIL rst_wait_outputs: ack/busy/err=%b data=%h required 000 00000000",
               {b_ack, b_busy, b_err}, b_rd); end
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) b_rst_n = 1'b1;
      if (b_ack === 1'b1) acks++;
    end
    n_cmp++; if (acks != 0) begin n_bad++;
      $display("FAIL rst_wait_noack: %0d acks seen, required 0", acks); end
    acc_b(1'b1, 7, 4'hF, 32'h0, rd, n, pre_ok, bat, baf);
    b_exp_rd = 32'h0;
    n_cmp++; if (rd !== b_exp_rd) begin n_bad++;
      $display("FAIL rst_wait_nowrite: got %h required %h", rd, b_exp_rd); end
  endtask

`ifdef LANE_RAM_WRPROT_EN
  task automatic test_wrprot();
    logic [15:0] rd; logic er; int n;
    acc_a(1'b0, 18'h20, 2'b11, 16'h1111, 1'b0, rd, er, n);
    acc_a(1'b0, 18'h20, 2'b11, 16'hFFFF, 1'b1, rd, er, n);
    n_cmp++; if (er !== 1'b1) begin n_bad++;
      $display("FAIL wp_err_low: got %b required 1", er); end
    acc_a(1'b1, 18'h20, 2'b11, 16'h0, 1'b1, rd, er, n);
    n_cmp++; if (rd !== 16'h1111 || er !== 1'b0) begin n_bad++;
      $display("FAIL wp_rd_low: data=%h err=%b required 1111 0", rd, er); end
    acc_a(1'b0, 18'h120, 2'b11, 16'hFFFF, 1'b1, rd, er, n);
    n_cmp++; if (er !== 1'b0) begin n_bad++;
      $display("FAIL wp_err_high: got %b required 0", er); end
    acc_a(1'b1, 18'h120, 2'b11, 16'h0, 1'b1, rd, er, n);
    n_cmp++; if (rd !== 16'hFFFF) begin n_bad++;
      $display("FAIL wp_rd_high: got %h required FFFF", rd); end
    model_a[32'h20] = 16'h1111;
    model_a[32'h120] = 16'hFFFF;
    a_exp_rd = 16'hFFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
`ifdef LANE_RAM_WRPROT_EN
    test_wrprot();
`endif
    test_random();
    test_wait_states();
    test_wrap();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
